// File: rtl/w_update_seq_pkg.sv
// Shared fixed-point defaults, constants and the update-sequencer state encoding
// used by the perceptron delta, update and forward stages.
package w_update_seq_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 24;

    localparam logic [WIDTH_DEF-1:0] FX_ONE  = {{(WIDTH_DEF-1){1'b0}}, 1'b1} << FRAC_DEF;
    localparam logic [WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    localparam logic [WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        SCALE,
        UPDATE,
        BIAS,
        DONE
    } upd_state_e;

endpackage

// File: rtl/fx_mulsub.sv
// Combinational fixed-point datapath: o_prod = sat_mul(a, b) and
// o_diff = sat_sub(acc, o_prod), both clamped to the signed WIDTH range.
module fx_mulsub
    import w_update_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_acc,
    output logic [WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0] o_diff
);

    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod_full;
    logic [2*WIDTH-1:0] prod_shr;
    logic [WIDTH:0]     diff_ext;

    // The shifted product fits only if its top WIDTH+1 bits are pure sign extension.
    always_comb begin
        a_ext     = {{WIDTH{i_a[WIDTH-1]}}, i_a};
        b_ext     = {{WIDTH{i_b[WIDTH-1]}}, i_b};
        prod_full = a_ext * b_ext;
        prod_shr  = $signed(prod_full) >>> FRAC;
        if (prod_shr[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){prod_shr[2*WIDTH-1]}}) begin
            o_prod = prod_shr[WIDTH-1:0];
        end else if (prod_shr[2*WIDTH-1]) begin
            o_prod = MINV;
        end else begin
            o_prod = MAXV;
        end

        diff_ext = {i_acc[WIDTH-1], i_acc} - {o_prod[WIDTH-1], o_prod};
        if (diff_ext[WIDTH] == diff_ext[WIDTH-1]) begin
            o_diff = diff_ext[WIDTH-1:0];
        end else if (diff_ext[WIDTH]) begin
            o_diff = MINV;
        end else begin
            o_diff = MAXV;
        end
    end

endmodule

// File: rtl/w_update_seq.sv
// Sequential SGD weight/bias update for one perceptron: one shared multiplier,
// one weight per cycle, then the bias; holds weights/bias for the forward path.
module w_update_seq
    import w_update_seq_pkg::*;
#(
    parameter int NUM   = 2,
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [NUM*WIDTH-1:0] i_w_init,
    input  logic [WIDTH-1:0]     i_b_init,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_delta,
    input  logic [NUM*WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0]     i_lr,
    output logic [NUM*WIDTH-1:0] o_w,
    output logic [WIDTH-1:0]     o_b,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int KW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [KW-1:0]    K_LAST = KW'(NUM - 1);
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

    upd_state_e state_q, state_d;

    logic [NUM*WIDTH-1:0] w_q;
    logic [NUM*WIDTH-1:0] x_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     delta_q;
    logic [WIDTH-1:0]     lr_q;
    logic [WIDTH-1:0]     g_q;
    logic [KW-1:0]        k_q;

    logic                 snap;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [WIDTH-1:0]     mul_acc;
    logic [WIDTH-1:0]     prod;
    logic [WIDTH-1:0]     diff;

    // DONE also accepts a start so back-to-back updates lose no cycle.
    always_comb begin
        state_d = state_q;
        snap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_load && i_start) begin
                    state_d = SCALE;
                    snap    = 1'b1;
                end
            end
            SCALE:  state_d = UPDATE;
            UPDATE: if (k_q == K_LAST) state_d = BIAS;
            BIAS:   state_d = DONE;
            DONE: begin
                if (i_start) begin
                    state_d = SCALE;
                    snap    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // BIAS reuses the multiplier with b = 1.0 so the product is exactly g.
    always_comb begin
        mul_a   = g_q;
        mul_b   = x_q[k_q*WIDTH +: WIDTH];
        mul_acc = w_q[k_q*WIDTH +: WIDTH];
        case (state_q)
            SCALE: begin
                mul_a   = lr_q;
                mul_b   = delta_q;
                mul_acc = '0;
            end
            BIAS: begin
                mul_b   = ONE_W;
                mul_acc = b_q;
            end
            default: ;
        endcase
    end

    fx_mulsub #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mulsub (
        .i_a    (mul_a),
        .i_b    (mul_b),
        .i_acc  (mul_acc),
        .o_prod (prod),
        .o_diff (diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q     <= '0;
            x_q     <= '0;
            b_q     <= '0;
            delta_q <= '0;
            lr_q    <= '0;
            g_q     <= '0;
            k_q     <= '0;
        end else begin
            if (snap) begin
                delta_q <= i_delta;
                x_q     <= i_x;
                lr_q    <= i_lr;
            end
            case (state_q)
                IDLE: begin
                    if (i_load) begin
                        w_q <= i_w_init;
                        b_q <= i_b_init;
                    end
                end
                SCALE: begin
                    g_q <= prod;
                    k_q <= '0;
                end
                UPDATE: begin
                    w_q[k_q*WIDTH +: WIDTH] <= diff;
                    if (k_q != K_LAST) k_q <= k_q + 1'b1;
                end
                BIAS: b_q <= diff;
                default: ;
            endcase
        end
    end

    assign o_w    = w_q;
    assign o_b    = b_q;
    assign o_busy = (state_q != IDLE);
    assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_w_update_seq.sv
// Self-checking bench for w_update_seq: directed scenarios plus randomized updates
// checked against a plain-arithmetic fixed-point reference model.
module tb_w_update_seq;

    localparam int NUM   = 2;
    localparam int WIDTH = 32;
    localparam int FRAC  = 24;

    logic                 clk;
    logic                 rst;
    logic                 i_load;
    logic                 i_start;
    logic [NUM*WIDTH-1:0] i_w_init;
    logic [NUM*WIDTH-1:0] i_x;
    logic [WIDTH-1:0]     i_b_init;
    logic [WIDTH-1:0]     i_delta;
    logic [WIDTH-1:0]     i_lr;
    logic [NUM*WIDTH-1:0] o_w;
    logic [WIDTH-1:0]     o_b;
    logic                 o_busy;
    logic                 o_done;

    int vectors     = 0;
    int miscompares = 0;
    int w_m[NUM];
    int b_m;

    w_update_seq #(.NUM(NUM), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_load   (i_load),
        .i_w_init (i_w_init),
        .i_b_init (i_b_init),
        .i_start  (i_start),
        .i_delta  (i_delta),
        .i_x      (i_x),
        .i_lr     (i_lr),
        .o_w      (o_w),
        .o_b      (o_b),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference arithmetic: real-valued rules on 64-bit integers, then clamp.
    function automatic int fx_sat(longint v);
        longint hi;
        longint lo;
        hi = 64'sd2147483647;
        lo = -64'sd2147483648;
        if (v > hi) return int'(hi);
        if (v < lo) return int'(lo);
        return int'(v);
    endfunction

    function automatic int fx_mul(int a, int b);
        longint p;
        p = longint'(a) * longint'(b);
        return fx_sat(p >>> FRAC);
    endfunction

    function automatic int fx_sub(int a, int b);
        return fx_sat(longint'(a) - longint'(b));
    endfunction

    function automatic void model_update(logic [WIDTH-1:0] delta, logic [WIDTH-1:0] lr,
                                         logic [NUM*WIDTH-1:0] x);
        int g;
        g = fx_mul(int'(lr), int'(delta));
        for (int k = 0; k < NUM; k++) w_m[k] = fx_sub(w_m[k], fx_mul(g, int'(x[k*WIDTH +: WIDTH])));
        b_m = fx_sub(b_m, g);
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return $signed(r) >>> 6;
            2:       return $signed(r) >>> 10;
            default: return $signed(r) >>> 14;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(logic [NUM*WIDTH-1:0] w, logic [WIDTH-1:0] b);
        i_w_init = w;
        i_b_init = b;
        i_load   = 1'b1;
        next_cycle();
        i_load   = 1'b0;
        for (int k = 0; k < NUM; k++) w_m[k] = int'(w[k*WIDTH +: WIDTH]);
        b_m = int'(b);
    endtask

    // Starts one update and watches a bounded window; scramble pokes inputs while busy.
    task automatic run_update(input logic [WIDTH-1:0] delta, input logic [WIDTH-1:0] lr,
                              input logic [NUM*WIDTH-1:0] x, input bit scramble,
                              output int first_done, output int n_done);
        i_delta = delta;
        i_lr    = lr;
        i_x     = x;
        i_start = 1'b1;
        next_cycle();
        i_start    = 1'b0;
        first_done = -1;
        n_done     = 0;
        for (int c = 1; c <= NUM + 6; c++) begin
            if (scramble && c <= NUM + 2) begin
                i_x      = {$urandom, $urandom};
                i_delta  = $urandom;
                i_lr     = $urandom;
                i_w_init = {$urandom, $urandom};
                i_b_init = $urandom;
                i_start  = 1'b1;
                i_load   = 1'b1;
            end else begin
                i_start = 1'b0;
                i_load  = 1'b0;
            end
            next_cycle();
            if (o_done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
        end
        model_update(delta, lr, x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12 rst = 1'b0;
        vectors++;
        if (o_w !== '0 || o_b !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_init: got w=%h b=%h expected 0", o_w, o_b);
        end
        do_load({32'h1111_1111, 32'h2222_2222}, 32'h3333_3333);
        vectors++;
        if (o_b !== 32'h3333_3333) begin
            miscompares++;
            $display("[TB] FAIL reset_preload: got b=%h expected 33333333", o_b);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (o_w !== '0 || o_b !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got w=%h b=%h busy=%b done=%b expected all 0", o_w, o_b, o_busy, o_done);
        end
        rst = 1'b0;
        for (int k = 0; k < NUM; k++) w_m[k] = 0;
        b_m = 0;
    endtask

    task automatic test_load();
        do_load({32'hFFC0_0000, 32'h0080_0000}, 32'h0020_0000);
        vectors++;
        if (o_w !== {32'hFFC0_0000, 32'h0080_0000}) begin
            miscompares++;
            $display("[TB] FAIL load_w: got %h expected ffc0000000800000", o_w);
        end
        vectors++;
        if (o_b !== 32'h0020_0000 || o_busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_b_busy: got b=%h busy=%b expected b=00200000 busy=0", o_b, o_busy);
        end
    endtask

    task automatic test_nominal(input bit scramble, input string tag);
        int fd;
        int nd;
        do_load({32'hFFC0_0000, 32'h0080_0000}, 32'h0020_0000);
        run_update(32'h0040_0000, 32'h0080_0000, {32'h0200_0000, 32'h0100_0000}, scramble, fd, nd);
        vectors++;
        if (fd !== NUM + 2 || nd !== 1) begin
            miscompares++;
            $display("[TB] FAIL %s_done: got first=%0d count=%0d expected first=%0d count=1", tag, fd, nd, NUM + 2);
        end
        vectors++;
        if (o_w !== {32'hFF80_0000, 32'h0060_0000}) begin
            miscompares++;
            $display("[TB] FAIL %s_w: got %h expected ff80000000600000", tag, o_w);
        end
        vectors++;
        if (o_b !== 32'h0000_0000) begin
            miscompares++;
            $display("[TB] FAIL %s_b: got %h expected 00000000", tag, o_b);
        end
    endtask

    task automatic test_saturation();
        int fd;
        int nd;
        do_load({32'h0010_0000, 32'h8080_0000}, 32'h0000_0000);
        run_update(32'h0100_0000, 32'h0100_0000, {32'h0080_0000, 32'h0100_0000}, 1'b0, fd, nd);
        vectors++;
        if (o_w[WIDTH-1:0] !== 32'h8000_0000) begin
            miscompares++;
            $display("[TB] FAIL sat_w0: got %h expected 80000000", o_w[WIDTH-1:0]);
        end
        vectors++;
        if (o_w[2*WIDTH-1:WIDTH] !== 32'(w_m[1]) || o_b !== 32'(b_m)) begin
            miscompares++;
            $display("[TB] FAIL sat_rest: got w1=%h b=%h expected w1=%h b=%h", o_w[2*WIDTH-1:WIDTH], o_b, w_m[1], b_m);
        end
        do_load('0, 32'h7FFF_FFFF);
        run_update(32'h7FFF_FFFF, 32'h7FFF_FFFF, '0, 1'b0, fd, nd);
        vectors++;
        if (o_b !== 32'h0000_0000 || o_w !== '0) begin
            miscompares++;
            $display("[TB] FAIL sat_g_max: got b=%h w=%h expected b=00000000 w=0", o_b, o_w);
        end
        do_load('0, 32'h0000_0000);
        run_update(32'h7FFF_FFFF, 32'h7FFF_FFFF, '0, 1'b0, fd, nd);
        vectors++;
        if (o_b !== 32'h8000_0001) begin
            miscompares++;
            $display("[TB] FAIL sat_neg_g: got %h expected 80000001", o_b);
        end
        do_load('0, 32'h0000_0000);
        run_update(32'h7FFF_FFFF, 32'h8000_0000, '0, 1'b0, fd, nd);
        vectors++;
        if (o_b !== 32'h7FFF_FFFF) begin
            miscompares++;
            $display("[TB] FAIL sat_sub_hi: got %h expected 7fffffff", o_b);
        end
    endtask

    task automatic test_reset_mid();
        do_load({32'hFFC0_0000, 32'h0080_0000}, 32'h0020_0000);
        i_delta = 32'h0040_0000;
        i_lr    = 32'h0080_0000;
        i_x     = {32'h0200_0000, 32'h0100_0000};
        i_start = 1'b1;
        next_cycle();
        i_start = 1'b0;
        next_cycle();
        next_cycle();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (o_w !== '0 || o_b !== '0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_clear: got w=%h b=%h busy=%b done=%b expected all 0", o_w, o_b, o_busy, o_done);
        end
        rst = 1'b0;
        next_cycle();
        next_cycle();
        vectors++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_w !== '0) begin
            miscompares++;
            $display("[TB] FAIL rstmid_idle: got busy=%b done=%b w=%h expected 0 0 0", o_busy, o_done, o_w);
        end
        test_nominal(1'b0, "rstmid_rerun");
    endtask

    task automatic test_back_to_back();
        int fd;
        int nd;
        do_load({32'hFFC0_0000, 32'h0080_0000}, 32'h0020_0000);
        i_delta = 32'h0040_0000;
        i_lr    = 32'h0080_0000;
        i_x     = {32'h0200_0000, 32'h0100_0000};
        i_start = 1'b1;
        next_cycle();
        i_start = 1'b0;
        for (int c = 1; c <= NUM + 2; c++) next_cycle();
        vectors++;
        if (o_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_done: got %b expected 1", o_done);
        end
        model_update(32'h0040_0000, 32'h0080_0000, {32'h0200_0000, 32'h0100_0000});
        i_start = 1'b1;
        next_cycle();
        i_start = 1'b0;
        vectors++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", o_busy, o_done);
        end
        fd = -1;
        nd = 0;
        for (int c = 1; c <= NUM + 5; c++) begin
            next_cycle();
            if (o_done) begin
                nd++;
                if (fd < 0) fd = c;
            end
        end
        model_update(32'h0040_0000, 32'h0080_0000, {32'h0200_0000, 32'h0100_0000});
        vectors++;
        if (fd !== NUM + 2 || nd !== 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_done: got first=%0d count=%0d expected first=%0d count=1", fd, nd, NUM + 2);
        end
        vectors++;
        if (o_w[WIDTH-1:0] !== 32'h0040_0000 || o_b !== 32'hFFE0_0000) begin
            miscompares++;
            $display("[TB] FAIL b2b_values: got w0=%h b=%h expected w0=00400000 b=ffe00000", o_w[WIDTH-1:0], o_b);
        end
        vectors++;
        if (o_w[2*WIDTH-1:WIDTH] !== 32'(w_m[1])) begin
            miscompares++;
            $display("[TB] FAIL b2b_w1: got %h expected %h", o_w[2*WIDTH-1:WIDTH], w_m[1]);
        end
    endtask

    task automatic test_random();
        int fd;
        int nd;
        for (int n = 0; n < 40; n++) begin
            do_load({rnd_word(), rnd_word()}, rnd_word());
            run_update(rnd_word(), rnd_word(), {rnd_word(), rnd_word()}, n[0], fd, nd);
            vectors++;
            if (fd !== NUM + 2 || nd !== 1) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_done: got first=%0d count=%0d expected first=%0d count=1", n, fd, nd, NUM + 2);
            end
            for (int k = 0; k < NUM; k++) begin
                vectors++;
                if (o_w[k*WIDTH +: WIDTH] !== 32'(w_m[k])) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_w%0d: got %h expected %h", n, k, o_w[k*WIDTH +: WIDTH], w_m[k]);
                end
            end
            vectors++;
            if (o_b !== 32'(b_m)) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_b: got %h expected %h", n, o_b, b_m);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_load   = 1'b0;
        i_start  = 1'b0;
        i_w_init = '0;
        i_b_init = '0;
        i_delta  = '0;
        i_x      = '0;
        i_lr     = '0;
        test_reset();
        test_load();
        test_nominal(1'b0, "nominal");
        test_saturation();
        test_nominal(1'b1, "ignored");
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
